// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART serial receiver with mid-bit sampling, parity/stop checking and sticky status
module uart_rx #(
    parameter int   CLKS_PER_BIT = 16,
    parameter logic PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       UART_BITS,
    input  logic       UART_PARITY,
    input  logic       UART_READ,
    output logic [7:0] DATA_OUT_Rx,
    output logic       DATA_VALID,
    output logic       IRQ_Rx,
    output logic       PARITY_ERR,
    output logic       FRAME_ERR,
    output logic       OVERRUN
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic          rx_meta_q, rx_meta_d, rx_s_q, rx_s_d, rx_prev_q, rx_prev_d;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          bits8_q, bits8_d, par_en_q, par_en_d, pbad_q, pbad_d;
    logic [7:0]    data_q, data_d;
    logic          dv_q, dv_d, irq_q, irq_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic          tick;
    logic [7:0]    byte_now;

    assign tick     = (cnt_q == '0);
    // Bits enter at the MSB, so a 7-bit frame ends up in shift_q[7:1].
    assign byte_now = bits8_q ? shift_q : {1'b0, shift_q[7:1]};

    always_comb begin
        rx_meta_d = RX_IN;
        rx_s_d    = rx_meta_q;
        rx_prev_d = rx_s_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        bits8_d   = bits8_q;
        par_en_d  = par_en_q;
        pbad_d    = pbad_q;
        data_d    = data_q;
        dv_d      = dv_q;
        irq_d     = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        ovr_d     = ovr_q;
        if (UART_READ) begin
            dv_d  = 1'b0;
            ovr_d = 1'b0;
        end
        if (state_q != S_IDLE) begin
            cnt_d = tick ? CNT_FULL : cnt_q - 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q && rx_prev_q) begin
                    state_d  = S_START;
                    cnt_d    = CNT_HALF;
                    bit_d    = '0;
                    bits8_d  = UART_BITS;
                    par_en_d = UART_PARITY;
                    pbad_d   = 1'b0;
                end
            end
            S_START: begin
                if (tick) state_d = rx_s_q ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == (bits8_q ? 3'd7 : 3'd6)) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    pbad_d  = ((^byte_now) ^ rx_s_q) != PARITY_ODD;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // Frame completion takes priority over a coincident host read.
                if (tick) begin
                    data_d  = byte_now;
                    perr_d  = par_en_q & pbad_q;
                    ferr_d  = ~rx_s_q;
                    dv_d    = 1'b1;
                    ovr_d   = UART_READ ? 1'b0 : (ovr_q | dv_q);
                    irq_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Synchronizer resets low so a line held low through reset is not taken as a start edge.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            rx_meta_q <= 1'b0;
            rx_s_q    <= 1'b0;
            rx_prev_q <= 1'b0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            bits8_q   <= 1'b0;
            par_en_q  <= 1'b0;
            pbad_q    <= 1'b0;
            data_q    <= '0;
            dv_q      <= 1'b0;
            irq_q     <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            rx_prev_q <= rx_prev_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            bits8_q   <= bits8_d;
            par_en_q  <= par_en_d;
            pbad_q    <= pbad_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            irq_q     <= irq_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign DATA_OUT_Rx = data_q;
    assign DATA_VALID  = dv_q;
    assign IRQ_Rx      = irq_q;
    assign PARITY_ERR  = perr_q;
    assign FRAME_ERR   = ferr_q;
    assign OVERRUN     = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with a frame-level reference model
module tb_uart_rx;
    localparam int   C    = 16;
    localparam logic PODD = 1'b0;

    logic       clk = 1'b0;
    logic       RST, RX_IN, UART_BITS, UART_PARITY, UART_READ;
    logic [7:0] DATA_OUT_Rx;
    logic       DATA_VALID, IRQ_Rx, PARITY_ERR, FRAME_ERR, OVERRUN;

    uart_rx #(.CLKS_PER_BIT(C), .PARITY_ODD(PODD)) dut (
        .clk(clk), .RST(RST), .RX_IN(RX_IN), .UART_BITS(UART_BITS),
        .UART_PARITY(UART_PARITY), .UART_READ(UART_READ),
        .DATA_OUT_Rx(DATA_OUT_Rx), .DATA_VALID(DATA_VALID), .IRQ_Rx(IRQ_Rx),
        .PARITY_ERR(PARITY_ERR), .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         t;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         n_chk = 0, n_fail = 0, irq_cnt = 0;
    bit         m_dv = 1'b0, m_ovr = 1'b0, coincide = 1'b0, exp_ovr;
    logic [7:0] m_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every IRQ pulse consumes one expected frame.
    always @(negedge clk) begin
        if (RST === 1'b1 && IRQ_Rx === 1'b1) begin
            irq_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_irq", 1, 0);
            end else begin
                e       = sb.pop_front();
                exp_ovr = m_dv && !coincide;
                check("irq_time", cyc, e.t);
                check("data", DATA_OUT_Rx, e.d);
                check("parity_err", PARITY_ERR, e.pe);
                check("frame_err", FRAME_ERR, e.fe);
                check("data_valid", DATA_VALID, 1);
                check("overrun", OVERRUN, exp_ovr);
                m_dv     = 1'b1;
                m_ovr    = exp_ovr;
                m_data   = e.d;
                coincide = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic host_read();
        @(negedge clk);
        UART_READ = 1'b1;
        @(negedge clk);
        UART_READ = 1'b0;
        m_dv  = 1'b0;
        m_ovr = 1'b0;
        check("read_clears_dv", DATA_VALID, 0);
        check("read_clears_ovr", OVERRUN, 0);
    endtask

    task automatic check_reset_values();
        check("rst_data", DATA_OUT_Rx, 8'h00);
        check("rst_dv", DATA_VALID, 0);
        check("rst_irq", IRQ_Rx, 0);
        check("rst_perr", PARITY_ERR, 0);
        check("rst_ferr", FRAME_ERR, 0);
        check("rst_ovr", OVERRUN, 0);
    endtask

    // cut >= 0 abandons the frame halfway through line slot 'cut' (0 = data bit 0).
    task automatic send_frame(input logic [7:0] d, input bit b8, input bit pen, input bit flip,
                              input bit stop, input bit rd_end, input int cut);
        logic [7:0] dm;
        logic       pb;
        int         n, texp;
        bit         slots[$];
        exp_t       x;
        dm = b8 ? d : {1'b0, d[6:0]};
        n  = b8 ? 8 : 7;
        pb = (^dm) ^ PODD ^ flip;
        for (int i = 0; i < n; i++) slots.push_back(dm[i]);
        if (pen) slots.push_back(pb);
        slots.push_back(stop);
        @(negedge clk);
        UART_BITS   = b8;
        UART_PARITY = pen;
        RX_IN       = 1'b0;
        texp = cyc + 1 + 2 + C / 2 + (n + int'(pen) + 1) * C;
        if (cut < 0) begin
            x.d = dm; x.pe = flip && pen; x.fe = !stop; x.t = texp;
            sb.push_back(x);
        end
        repeat (C) @(negedge clk);
        UART_BITS   = 1'($urandom);
        UART_PARITY = 1'($urandom);
        for (int k = 0; k < slots.size(); k++) begin
            RX_IN = slots[k];
            if (k == cut) begin
                repeat (C / 2) @(negedge clk);
                return;
            end
            for (int j = 0; j < C; j++) begin
                @(negedge clk);
                if (rd_end) begin
                    UART_READ = (cyc == texp - 1);
                    if (cyc == texp - 1) coincide = 1'b1;
                end
            end
        end
        UART_READ = 1'b0;
        RX_IN     = 1'b1;
    endtask

    int c0;

    initial begin
        RST = 1'b0; RX_IN = 1'b1; UART_BITS = 1'b1; UART_PARITY = 1'b0; UART_READ = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        RST = 1'b1;
        idle(5);

        send_frame(8'hA5, 1, 0, 0, 1, 0, -1);
        idle(4);
        send_frame(8'h35, 0, 1, 1, 1, 0, -1);
        idle(4);
        send_frame(8'h35, 0, 1, 0, 1, 0, -1);
        idle(4);

        c0 = irq_cnt;
        @(negedge clk);
        RX_IN = 1'b0;
        repeat (4) @(negedge clk);
        idle(3 * C);
        check("glitch_no_irq", irq_cnt, c0);
        check("glitch_data", DATA_OUT_Rx, m_data);
        check("glitch_dv", DATA_VALID, m_dv);
        check("glitch_perr", PARITY_ERR, 0);

        host_read();
        send_frame(8'h3C, 1, 0, 0, 0, 0, -1);
        idle(C);

        host_read();
        send_frame(8'h11, 1, 0, 0, 1, 0, -1);
        send_frame(8'h22, 1, 0, 0, 1, 0, -1);
        idle(4);
        host_read();
        send_frame(8'h33, 1, 0, 0, 1, 0, -1);
        send_frame(8'h44, 1, 0, 0, 1, 1, -1);
        idle(4);

        send_frame(8'h96, 1, 0, 0, 1, 0, 3);
        RST = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values();
        m_dv = 1'b0; m_ovr = 1'b0; m_data = 8'h00;
        RX_IN = 1'b1;
        @(negedge clk);
        RST = 1'b1;
        c0 = irq_cnt;
        idle(2 * C);
        check("reset_abort_no_irq", irq_cnt, c0);
        send_frame(8'h5A, 1, 0, 0, 1, 0, -1);
        idle(4);

        for (int f = 0; f < 24; f++) begin
            logic [7:0] d;
            bit b8, pen, flip, stop;
            d    = 8'($urandom);
            b8   = 1'($urandom);
            pen  = 1'($urandom);
            flip = ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(d, b8, pen, flip, stop, 0, -1);
            if (!stop) idle(C);
            else idle($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) host_read();
        end

        for (int i = 0; i < 1000 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
